// File: rtl/mesh_edge_injector_pkg.sv
// Shared mesh definitions: packet geometry, NOP key and injector state encoding.
// Also used by the PE.
package mesh_edge_injector_pkg;

   localparam int MESH_N      = 1024;
   localparam int MESH_SQRT_N = 32;
   localparam int KEY_WIDTH   = 10;
   localparam int VAL_WIDTH   = 10;
   localparam int PKT_WIDTH   = KEY_WIDTH + VAL_WIDTH;
   localparam int NOP_KEY     = MESH_N;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      INJECT = 2'd1,
      CLEAR  = 2'd2
   } state_t;

   // Bits needed to represent max_value; never less than one.
   function automatic int count_width(input int max_value);
      return (max_value < 2) ? 1 : $clog2(max_value + 1);
   endfunction

endpackage

// File: rtl/mesh_edge_injector_if.sv
// Host packet handshake into the mesh edge injector.
interface mesh_edge_injector_if
   import mesh_edge_injector_pkg::*;
#(
   parameter int WIDTH = PKT_WIDTH
) ();

   logic             i_valid;
   logic             o_ready;
   logic [WIDTH-1:0] i_pkt;

   modport master (output i_valid, output i_pkt, input o_ready);
   modport slave  (input i_valid, input i_pkt, output o_ready);

endinterface

// File: rtl/mesh_edge_injector_counter.sv
// Free-running up counter with synchronous clear.
module mesh_edge_injector_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] counter
);

   always_ff @(posedge clk) begin
      if (rst) counter <= '0;
      else     counter <= counter + WIDTH'(1);
   end

endmodule

// File: rtl/mesh_edge_injector.sv
// Collects host packets into per-row slots, then drives them onto the mesh
// row edges for a fixed hold window before clearing back to NOP.
module mesh_edge_injector
   import mesh_edge_injector_pkg::*;
#(
   parameter int N           = NOP_KEY,
   parameter int SQRT_N      = MESH_SQRT_N,
   parameter int ADDR_WIDTH  = KEY_WIDTH,
   parameter int DATA_WIDTH  = VAL_WIDTH,
   parameter int HOLD_CYCLES = SQRT_N
) (
   input  logic                                        clk,
   input  logic                                        rst,
   mesh_edge_injector_if.slave                         host,
   input  logic                                        i_start,
   output logic [SQRT_N*(ADDR_WIDTH+DATA_WIDTH)-1:0]   o_edge,
   output logic                                        o_busy,
   output logic                                        o_done,
   output logic                                        o_err,
   output logic [$clog2(SQRT_N+1)-1:0]                 o_count
);

   localparam int WIDTH = ADDR_WIDTH + DATA_WIDTH;
   localparam int CW    = $clog2(SQRT_N + 1);
   localparam int HW    = count_width(HOLD_CYCLES - 1);
   localparam logic [WIDTH-1:0] NOP_PKT = {ADDR_WIDTH'(N), DATA_WIDTH'(0)};

   state_t                  state;
   state_t                  state_next;
   logic [HW-1:0]           hold;
   logic                    hold_rst;
   logic                    hold_last;
   logic                    handshake;
   logic                    key_illegal;
   logic [ADDR_WIDTH-1:0]   key;
   logic [WIDTH-1:0]        slot [SQRT_N];

   assign key         = host.i_pkt[WIDTH-1:DATA_WIDTH];
   assign key_illegal = 32'(key) > 32'(N);
   assign handshake   = host.i_valid && host.o_ready;
   assign hold_last   = (hold == HW'(HOLD_CYCLES - 1));

   // Clearing on any state transition makes hold read 0 in the first INJECT cycle.
   assign hold_rst = rst || (state != state_next);

   mesh_edge_injector_counter #(
      .WIDTH (HW)
   ) u_hold (
      .clk     (clk),
      .rst     (hold_rst),
      .counter (hold)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next   = state;
      host.o_ready = 1'b0;
      o_busy       = 1'b0;
      unique case (state)
         IDLE: begin
            host.o_ready = (o_count < CW'(SQRT_N)) && !i_start;
            if (i_start) state_next = INJECT;
         end
         INJECT: begin
            o_busy = 1'b1;
            if (hold_last) state_next = CLEAR;
         end
         CLEAR: begin
            o_busy     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || state == CLEAR) begin
         for (int unsigned i = 0; i < SQRT_N; i++) slot[i] <= NOP_PKT;
         o_count <= '0;
      end else if (handshake && !key_illegal) begin
         for (int unsigned i = 0; i < SQRT_N; i++) begin
            if (o_count == CW'(i)) slot[i] <= host.i_pkt;
         end
         o_count <= o_count + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_done <= 1'b0;
         o_err  <= 1'b0;
      end else begin
         o_done <= (state == CLEAR);
         o_err  <= handshake && key_illegal;
      end
   end

   always_comb begin
      o_edge = '0;
      for (int unsigned r = 0; r < SQRT_N; r++) begin
         o_edge[r*WIDTH +: WIDTH] = (state == INJECT) ? slot[r] : NOP_PKT;
      end
   end

endmodule

// File: tb/tb_mesh_edge_injector.sv
// Scenario bench for mesh_edge_injector; accepted packets are queued and
// compared against the row edges when the inject window opens.
module tb_mesh_edge_injector;

   localparam int N    = 1024;
   localparam int SQ   = 32;
   localparam int AW   = 11;   // wide enough that keys N and N+1 are representable
   localparam int DW   = 10;
   localparam int HOLD = 32;
   localparam int W    = AW + DW;
   localparam int EW   = SQ * W;
   localparam int CW   = $clog2(SQ + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          i_start;
   logic [EW-1:0] o_edge;
   logic          o_busy;
   logic          o_done;
   logic          o_err;
   logic [CW-1:0] o_count;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q [$];

   mesh_edge_injector_if #(.WIDTH(W)) host ();

   mesh_edge_injector #(
      .N           (N),
      .SQRT_N      (SQ),
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .HOLD_CYCLES (HOLD)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .host    (host),
      .i_start (i_start),
      .o_edge  (o_edge),
      .o_busy  (o_busy),
      .o_done  (o_done),
      .o_err   (o_err),
      .o_count (o_count)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [W-1:0] mk(input int key, input int data);
      return {AW'(key), DW'(data)};
   endfunction

   function automatic logic [EW-1:0] all_nop();
      logic [EW-1:0] e;
      for (int r = 0; r < SQ; r++) e[r*W +: W] = mk(N, 0);
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      host.i_valid = 1'b0;
      i_start = 1'b0;
      step();
      step();
      rst = 1'b0;
      exp_q.delete();
   endtask

   // Drives one packet for a cycle; only call in IDLE with i_start low.
   task automatic send(input int key, input int data);
      host.i_valid = 1'b1;
      host.i_pkt   = mk(key, data);
      step();
      host.i_valid = 1'b0;
      if (key <= N && exp_q.size() < SQ) exp_q.push_back(mk(key, data));
   endtask

   task automatic pop_expected(output logic [EW-1:0] e);
      for (int r = 0; r < SQ; r++) begin
         if (exp_q.size() > 0) e[r*W +: W] = exp_q.pop_front();
         else                  e[r*W +: W] = mk(N, 0);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      host.i_valid = 1'b0;
      host.i_pkt = '0;
      i_start = 1'b0;
      repeat (3) step();
      checks++; if (o_ready_now() !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", o_ready_now()); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
      checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", o_done); end
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", o_err); end
      checks++; if (o_count !== CW'(0)) begin errors++; $display("FAIL reset_count: got %0d expected 0", o_count); end
      checks++; if (o_edge !== all_nop()) begin errors++; $display("FAIL reset_edge: got %h expected %h", o_edge, all_nop()); end
      rst = 1'b0;
      exp_q.delete();
   endtask

   function automatic logic o_ready_now();
      return host.o_ready;
   endfunction

   task automatic test_inject_basic();
      logic [EW-1:0] exp;
      int done_at = 0;
      send(5, 1);
      send(40, 2);
      send(1024, 3);
      checks++; if (o_count !== CW'(3)) begin errors++; $display("FAIL basic_count: got %0d expected 3", o_count); end
      pop_expected(exp);
      i_start = 1'b1;
      for (int c = 1; c <= 100; c++) begin
         step();
         if (c == 1) i_start = 1'b0;
         if (c <= HOLD) begin
            checks++; if (o_edge !== exp) begin errors++; $display("FAIL basic_edge c%0d: got %h expected %h", c, o_edge, exp); end
            checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL basic_busy c%0d: got %b expected 1", c, o_busy); end
         end else if (c == HOLD + 1) begin
            checks++; if (o_edge !== all_nop()) begin errors++; $display("FAIL basic_clear_edge: got %h expected %h", o_edge, all_nop()); end
            checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL basic_clear_busy: got %b expected 1", o_busy); end
         end
         if (o_done === 1'b1) begin
            done_at = c;
            break;
         end
      end
      checks++; if (done_at != HOLD + 2) begin errors++; $display("FAIL basic_done_latency: got %0d expected %0d", done_at, HOLD + 2); end
      checks++; if (o_count !== CW'(0)) begin errors++; $display("FAIL basic_count_after: got %0d expected 0", o_count); end
      step();
      checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", o_done); end
   endtask

   task automatic test_back_to_back();
      logic [EW-1:0] exp;
      do_reset();
      host.i_valid = 1'b1;
      for (int i = 0; i < SQ; i++) begin
         host.i_pkt = mk(100 + i, i);
         #1;
         checks++; if (host.o_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready %0d: got %b expected 1", i, host.o_ready); end
         step();
         exp_q.push_back(mk(100 + i, i));
      end
      host.i_pkt = mk(77, 7);
      #1;
      checks++; if (host.o_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %b expected 0", host.o_ready); end
      checks++; if (o_count !== CW'(SQ)) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", o_count, SQ); end
      step();
      step();
      checks++; if (o_count !== CW'(SQ)) begin errors++; $display("FAIL b2b_33rd: got %0d expected %0d", o_count, SQ); end
      host.i_valid = 1'b0;
      pop_expected(exp);
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      checks++; if (o_edge !== exp) begin errors++; $display("FAIL b2b_edge: got %h expected %h", o_edge, exp); end
      do_reset();
   endtask

   task automatic test_illegal_key();
      do_reset();
      send(7, 9);
      checks++; if (o_count !== CW'(1)) begin errors++; $display("FAIL illegal_pre_count: got %0d expected 1", o_count); end
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL illegal_pre_err: got %b expected 0", o_err); end
      host.i_valid = 1'b1;
      host.i_pkt = mk(N + 1, 5);
      step();
      host.i_valid = 1'b0;
      checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL illegal_err: got %b expected 1", o_err); end
      checks++; if (o_count !== CW'(1)) begin errors++; $display("FAIL illegal_count: got %0d expected 1", o_count); end
      step();
      checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL illegal_err_pulse: got %b expected 0", o_err); end
   endtask

   task automatic test_start_collision();
      logic [EW-1:0] exp;
      logic seen = 1'b0;
      do_reset();
      host.i_valid = 1'b1;
      host.i_pkt = mk(9, 4);
      i_start = 1'b1;
      #1;
      checks++; if (host.o_ready !== 1'b0) begin errors++; $display("FAIL coll_ready: got %b expected 0", host.o_ready); end
      step();
      i_start = 1'b0;
      checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL coll_busy: got %b expected 1", o_busy); end
      checks++; if (o_edge !== all_nop()) begin errors++; $display("FAIL coll_edge: got %h expected %h", o_edge, all_nop()); end
      for (int c = 0; c < 100; c++) begin
         step();
         if (o_done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL coll_done_timeout: got %b expected 1", seen); end
      checks++; if (o_count !== CW'(0)) begin errors++; $display("FAIL coll_count_pending: got %0d expected 0", o_count); end
      checks++; if (host.o_ready !== 1'b1) begin errors++; $display("FAIL coll_ready_after: got %b expected 1", host.o_ready); end
      step();
      host.i_valid = 1'b0;
      exp_q.push_back(mk(9, 4));
      checks++; if (o_count !== CW'(1)) begin errors++; $display("FAIL coll_accept: got %0d expected 1", o_count); end
      pop_expected(exp);
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      checks++; if (o_edge !== exp) begin errors++; $display("FAIL coll_edge_after: got %h expected %h", o_edge, exp); end
      do_reset();
   endtask

   task automatic test_reset_abort();
      logic [EW-1:0] exp;
      logic done_seen = 1'b0;
      do_reset();
      send(3, 3);
      pop_expected(exp);
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      repeat (9) step();
      checks++; if (o_edge !== exp) begin errors++; $display("FAIL abort_edge_c10: got %h expected %h", o_edge, exp); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", o_busy); end
      checks++; if (o_count !== CW'(0)) begin errors++; $display("FAIL abort_count: got %0d expected 0", o_count); end
      checks++; if (o_edge !== all_nop()) begin errors++; $display("FAIL abort_edge: got %h expected %h", o_edge, all_nop()); end
      checks++; if (host.o_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", host.o_ready); end
      for (int c = 0; c < 40; c++) begin
         if (o_done === 1'b1) done_seen = 1'b1;
         step();
      end
      checks++; if (done_seen !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %b expected 0", done_seen); end
   endtask

   task automatic test_empty_start();
      int done_at = 0;
      do_reset();
      i_start = 1'b1;
      for (int c = 1; c <= 100; c++) begin
         step();
         if (c == 1) i_start = 1'b0;
         if (c <= HOLD + 1) begin
            checks++; if (o_edge !== all_nop()) begin errors++; $display("FAIL empty_edge c%0d: got %h expected %h", c, o_edge, all_nop()); end
         end
         if (c == 1) begin
            checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL empty_busy: got %b expected 1", o_busy); end
         end
         if (o_done === 1'b1) begin
            done_at = c;
            break;
         end
      end
      checks++; if (done_at != HOLD + 2) begin errors++; $display("FAIL empty_done_latency: got %0d expected %0d", done_at, HOLD + 2); end
   endtask

   initial begin
      test_reset();
      test_inject_basic();
      test_back_to_back();
      test_illegal_key();
      test_start_collision();
      test_reset_abort();
      test_empty_start();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mesh_edge_injector.md
MESH_EDGE_INJECTOR -- requirements
Module: mesh_edge_injector

Interface
REQ-001 The block SHALL have a parameter N, default 1024, giving the total PE count of the mesh.
REQ-002 The block SHALL have a parameter SQRT_N, default 32, giving the mesh side length and the number of row edge ports.
REQ-003 The block SHALL have parameters ADDR_WIDTH, default 10, and DATA_WIDTH, default 10; WIDTH = ADDR_WIDTH+DATA_WIDTH is the packet width.
REQ-004 The block SHALL have a parameter HOLD_CYCLES, default SQRT_N, giving the number of cycles edge outputs are held in INJECT.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 i_valid  input  1  host packet valid.
REQ-008 o_ready  output  1  block can accept a packet this cycle.
REQ-009 i_pkt  input  WIDTH  host packet; key in [WIDTH-1:DATA_WIDTH], data in [DATA_WIDTH-1:0].
REQ-010 i_start  input  1  single-cycle pulse from the mesh controller that opens the inject window.
REQ-011 o_edge  output  SQRT_N*WIDTH  row edge packets; slice r drives the left-neighbour input of the first PE in row r.
REQ-012 o_busy  output  1  high in INJECT and CLEAR.
REQ-013 o_done  output  1  one-cycle pulse on the cycle CLEAR returns to IDLE.
REQ-014 o_err  output  1  one-cycle pulse when a packet is dropped for an illegal key.
REQ-015 o_count  output  clog2(SQRT_N+1)  number of slots currently filled.

Function
REQ-016 The block SHALL implement the states IDLE, INJECT and CLEAR.
REQ-017 A handshake SHALL occur when i_valid and o_ready are both high at a clock edge.
REQ-018 o_ready SHALL be high only in IDLE, with o_count < SQRT_N, and i_start low.
REQ-019 On a handshake with key <= N, the packet SHALL be written to slot o_count, and o_count SHALL increment by 1 at that edge.
REQ-020 On a handshake with key > N, the packet SHALL be discarded, o_count SHALL be unchanged, and o_err SHALL be high the next cycle.
REQ-021 A key equal to N (the NOP key) SHALL be stored like any legal key.
REQ-022 Empty slots SHALL hold key = N and data = 0.
REQ-023 In IDLE and CLEAR, every o_edge slice SHALL read key = N and data = 0.
REQ-024 When i_start is high in IDLE, the state SHALL become INJECT at the next edge, whatever the value of o_count (0 is allowed).
REQ-025 When i_valid and i_start are both high in IDLE, no packet SHALL be accepted, and the packet SHALL remain pending on the host side.
REQ-026 In INJECT, o_edge slice r SHALL equal slot r.
REQ-027 The block SHALL hold INJECT for exactly HOLD_CYCLES cycles, counted by an internal counter that resets on entry, and then move to CLEAR.
REQ-028 i_start received while not in IDLE SHALL be ignored.
REQ-029 CLEAR SHALL last exactly one cycle, in which all slots are set to empty and o_count is set to 0; the state SHALL then become IDLE.
REQ-030 o_done SHALL be high during the first IDLE cycle after CLEAR.
REQ-031 Latency from the i_start edge to the first valid o_edge data SHALL be 1 cycle.
REQ-032 Latency from the i_start edge to o_done SHALL be HOLD_CYCLES+2 cycles.

Reset
REQ-033 On rst, the block SHALL enter state IDLE.
REQ-034 On rst, all slots SHALL be set to empty, and o_count and the hold counter SHALL be set to 0.
REQ-035 On rst, o_done, o_err and o_busy SHALL be 0, and o_ready SHALL be 1.
REQ-036 rst asserted during INJECT SHALL abort the window, and o_edge SHALL read all NOP on the next cycle.

Structure
REQ-037 The packet width, the state encoding and the NOP key (N) SHALL be defined in the shared mesh package used by the PE.
REQ-038 The hold counter SHALL reuse the existing counter sub-module (clk, rst, counter), with rst driven by rst OR a state change.
REQ-039 The block SHALL contain no other sub-modules.

Verification
REQ-040 The bench SHALL cover: reset, then 3 packets (key 5 data 1, key 40 data 2, key 1024 data 3), then i_start -> o_edge rows 0..2 carry those packets and rows 3..31 carry key 1024, for 32 cycles; o_done 34 cycles after i_start.
REQ-041 The bench SHALL cover: 32 back-to-back handshakes -> o_count = 32 and o_ready low; a 33rd valid is not accepted.
REQ-042 The bench SHALL cover: packet with key 1025 -> o_err pulses 1 cycle and o_count is unchanged.
REQ-043 The bench SHALL cover: i_valid and i_start high in the same IDLE cycle -> no acceptance, INJECT entered, and the packet is accepted after o_done.
REQ-044 The bench SHALL cover: rst asserted at INJECT cycle 10 -> next cycle IDLE, o_count = 0, all rows NOP, no o_done pulse.
REQ-045 The bench SHALL cover: i_start with o_count = 0 -> INJECT with all rows NOP, and o_done after HOLD_CYCLES+2 cycles.
